// File: rtl/store_box_pkg.sv
// Shared types and constants for the store_box read-modify-write store unit.
package store_box_pkg;

  typedef enum logic [1:0] {
    ST_WORD = 2'b00,
    ST_HALF = 2'b01,
    ST_BYTE = 2'b10
  } store_type_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam int          CNT_W           = 3;

  // The reserved encoding 2'b11 behaves as a full-word store.
  function automatic logic is_word(input logic [1:0] store_type);
    return !((store_type == ST_HALF) || (store_type == ST_BYTE));
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: places the byte/halfword/word of wdata into the
// old memory word according to the little-endian lane selected by addr[1:0].
module store_lane_merge
  import store_box_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  store_type_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o
);

  logic [3:0] lane_en;

  always_comb begin
    lane_en = 4'b1111;
    if (store_type_i == ST_BYTE) begin
      lane_en = 4'b0001 << addr_lo_i;
    end else if (store_type_i == ST_HALF) begin
      lane_en = addr_lo_i[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Each byte lane picks its source byte from wdata, or keeps the old byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] src;

    always_comb begin
      src = wdata_i[8*gi +: 8];
      if (store_type_i == ST_BYTE) begin
        src = wdata_i[7:0];
      end else if (store_type_i == ST_HALF) begin
        src = wdata_i[8*(gi%2) +: 8];
      end
    end

    assign merged_o[8*gi +: 8] = lane_en[gi] ? src : old_word_i[8*gi +: 8];
  end

endmodule

// File: rtl/store_box.sv
// Store unit for sw/sh/sb: word stores write directly, sub-word stores do a
// read-modify-write of the addressed word. Optional macro: STORE_BOX_ALIGN_CHECK_EN.
module store_box
  import store_box_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        type_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic              busy_q;
  logic              done_q;
  logic              misaligned_q;
  logic [31:0]       merged_d;
  logic              misalign_d;

`ifdef STORE_BOX_ALIGN_CHECK_EN
  assign misalign_d = ((store_type == ST_HALF) && addr[0]) ||
                      (is_word(store_type) && (addr[1:0] != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  store_lane_merge u_merge (
    .old_word_i   (mem_rdata),
    .wdata_i      (wdata_q),
    .store_type_i (type_q),
    .addr_lo_i    (addr_lo_q),
    .merged_o     (merged_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      type_q       <= '0;
      addr_lo_q    <= '0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses raised on entry to their state.
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            type_q     <= store_type;
            addr_lo_q  <= addr[1:0];
            wdata_q    <= wdata;
            mem_addr_q <= addr & WORD_ALIGN_MASK;
            busy_q     <= 1'b1;
            if (misalign_d) begin
              state_q      <= S_DONE;
              misaligned_q <= 1'b1;
            end else if (is_word(store_type)) begin
              state_q     <= S_WRITE;
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= wdata;
            end else begin
              state_q  <= S_READ;
              mem_rd_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          state_q <= S_WAIT;
          cnt_q   <= WAIT_INIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= S_WRITE;
            mem_wr_q    <= 1'b1;
            mem_wdata_q <= merged_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WRITE: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_store_box.sv
// Bench for store_box: two instances (MEM_LATENCY 1 and 3) share stimulus, each
// backed by its own behavioural memory; results are compared to a word-level model.
module tb_store_box;

`ifdef STORE_BOX_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  store_type = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata_w    [2];
  logic [31:0] mem_addr_w [2];
  logic [31:0] mem_wdata_w[2];
  logic        mem_rd_w   [2];
  logic        mem_wr_w   [2];
  logic        busy_w     [2];
  logic        done_w     [2];
  logic        mis_w      [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    store_box #(.MEM_LATENCY((gi == 0) ? 1 : 3)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .store_type (store_type),
      .addr       (addr),
      .wdata      (wdata),
      .mem_rdata  (rdata_w[gi]),
      .mem_addr   (mem_addr_w[gi]),
      .mem_rd     (mem_rd_w[gi]),
      .mem_wr     (mem_wr_w[gi]),
      .mem_wdata  (mem_wdata_w[gi]),
      .busy       (busy_w[gi]),
      .done       (done_w[gi]),
      .misaligned (mis_w[gi])
    );
  end

  logic [31:0] mem [2][256];
  int          pend[2];
  logic [31:0] raddr[2];
  int          rd_cnt[2], wr_cnt[2], done_cnt[2], mis_cnt[2], fin_tick[2];
  logic [31:0] rd_addr[2], wr_addr[2];
  logic        busy1[2];
  int          tc;
  int          passed = 0;
  int          total = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference: replace the addressed byte/halfword (or whole word) by masking.
  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [1:0] t,
                                            input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask, ins;
    int sh;
    if (t == 2'd2) begin
      sh   = 8 * int'(a[1:0]);
      mask = 32'hFF << sh;
      ins  = (wd & 32'hFF) << sh;
    end else if (t == 2'd1) begin
      sh   = a[1] ? 16 : 0;
      mask = 32'hFFFF << sh;
      ins  = (wd & 32'hFFFF) << sh;
    end else begin
      mask = 32'hFFFF_FFFF;
      ins  = wd;
    end
    return (old & ~mask) | ins;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s dut%0d: got %h expected %h", name, d, obs, exp);
  endtask

  // One clock: observe outputs at the falling edge and play the memory.
  task automatic tick();
    @(negedge clk);
    tc++;
    for (int d = 0; d < 2; d++) begin
      if (mem_rd_w[d]) begin
        rd_cnt[d]++;
        rd_addr[d] = mem_addr_w[d];
        raddr[d]   = mem_addr_w[d];
        pend[d]    = lat_of(d);
        rdata_w[d] = $urandom;
      end else if (pend[d] > 0) begin
        pend[d]--;
        rdata_w[d] = (pend[d] == 0) ? mem[d][raddr[d][9:2]] : $urandom;
      end else begin
        rdata_w[d] = $urandom;
      end
      if (mem_wr_w[d]) begin
        wr_cnt[d]++;
        wr_addr[d] = mem_addr_w[d];
        mem[d][mem_addr_w[d][9:2]] = mem_wdata_w[d];
      end
      if (done_w[d]) done_cnt[d]++;
      if (mis_w[d]) mis_cnt[d]++;
      if ((done_w[d] || mis_w[d]) && fin_tick[d] < 0) fin_tick[d] = tc;
    end
  endtask

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      rd_cnt[d] = 0; wr_cnt[d] = 0; done_cnt[d] = 0; mis_cnt[d] = 0;
      fin_tick[d] = -1; rd_addr[d] = '0; wr_addr[d] = '0;
    end
    tc = 0;
  endtask

  task automatic check_idle_outputs(input string name);
    for (int d = 0; d < 2; d++) begin
      check({name, "_flags"}, d, 32'({mem_rd_w[d], mem_wr_w[d], busy_w[d], done_w[d], mis_w[d]}), 32'd0);
      check({name, "_addr"}, d, mem_addr_w[d], 32'd0);
      check({name, "_wdata"}, d, mem_wdata_w[d], 32'd0);
    end
  endtask

  task automatic run_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd,
                           input bit glitch);
    logic [31:0] expw[2];
    int  explat[2];
    bit  word, mis, rmw;
    word = (t == 2'd0) || (t == 2'd3);
    mis  = ALIGN && (((t == 2'd1) && a[0]) || (word && (a[1:0] != 2'b00)));
    rmw  = !mis && !word;
    clear_mon();
    for (int d = 0; d < 2; d++) begin
      expw[d]   = mis ? mem[d][a[9:2]] : ref_merge(mem[d][a[9:2]], t, a, wd);
      explat[d] = mis ? 1 : (word ? 2 : 3 + lat_of(d));
    end
    store_type = t; addr = a; wdata = wd; start = 1'b1;
    tick();
    start = 1'b0;
    for (int d = 0; d < 2; d++) busy1[d] = busy_w[d];
    if (glitch) begin
      // A second request while busy must be dropped.
      store_type = t ^ 2'b01; addr = ~a; wdata = ~wd; start = 1'b1;
      tick();
      start = 1'b0;
    end
    while ((fin_tick[0] < 0 || fin_tick[1] < 0) && tc < 60) tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("latency", d, fin_tick[d], explat[d]);
      check("rd_cnt", d, rd_cnt[d], rmw ? 1 : 0);
      check("wr_cnt", d, wr_cnt[d], mis ? 0 : 1);
      check("done_cnt", d, done_cnt[d], mis ? 0 : 1);
      check("mis_cnt", d, mis_cnt[d], mis ? 1 : 0);
      check("rd_addr", d, rd_addr[d], rmw ? (a & 32'hFFFF_FFFC) : 32'd0);
      check("wr_addr", d, wr_addr[d], mis ? 32'd0 : (a & 32'hFFFF_FFFC));
      check("mem_word", d, mem[d][a[9:2]], expw[d]);
      check("busy_start", d, 32'(busy1[d]), 32'd1);
      check("busy_end", d, 32'(busy_w[d]), 32'd0);
    end
    $display("store t=%0d addr=%h wdata=%h glitch=%0d -> dut0 word=%h lat=%0d, dut1 word=%h lat=%0d",
             t, a, wd, glitch, mem[0][a[9:2]], fin_tick[0], mem[1][a[9:2]], fin_tick[1]);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[0][i] = v;
      mem[1][i] = v;
    end
    for (int d = 0; d < 2; d++) begin
      pend[d] = 0; raddr[d] = '0; rdata_w[d] = '0;
    end
    clear_mon();
    reset = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b1;
    tick();

    // Directed cases with absolute expected words.
    mem[0][8'h40] = 32'hAABBCCDD; mem[1][8'h40] = 32'hAABBCCDD;
    run_store(2'd2, 32'h102, 32'h12345677, 1'b0);
    check("tp_sb", 0, mem[0][8'h40], 32'hAA77CCDD);
    check("tp_sb", 1, mem[1][8'h40], 32'hAA77CCDD);

    mem[0][8'h80] = 32'h11223344; mem[1][8'h80] = 32'h11223344;
    run_store(2'd1, 32'h202, 32'hFFFFBEEF, 1'b0);
    check("tp_sh_hi", 0, mem[0][8'h80], 32'hBEEF3344);
    mem[0][8'h80] = 32'h11223344; mem[1][8'h80] = 32'h11223344;
    run_store(2'd1, 32'h200, 32'hFFFFBEEF, 1'b0);
    check("tp_sh_lo", 1, mem[1][8'h80], 32'h1122BEEF);

    run_store(2'd0, 32'h40, 32'hDEADBEEF, 1'b0);
    check("tp_sw", 0, mem[0][8'h10], 32'hDEADBEEF);

    mem[0][8'h80] = 32'h11223344; mem[1][8'h80] = 32'h11223344;
    run_store(2'd1, 32'h203, 32'hCAFEF00D, 1'b0);
    run_store(2'd3, 32'h301, 32'h0BADCAFE, 1'b0);

    // Reset during WAIT: no write may follow, outputs clear on the next cycle.
    begin
      logic [31:0] keep0, keep1;
      keep0 = mem[0][8'h41]; keep1 = mem[1][8'h41];
      clear_mon();
      store_type = 2'd2; addr = 32'h105; wdata = $urandom; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      pend[0] = 0; pend[1] = 0;
      check_idle_outputs("abort");
      reset = 1'b1;
      repeat (8) tick();
      for (int d = 0; d < 2; d++) begin
        check("abort_wr", d, wr_cnt[d], 0);
        check("abort_done", d, done_cnt[d], 0);
      end
      check("abort_mem", 0, mem[0][8'h41], keep0);
      check("abort_mem", 1, mem[1][8'h41], keep1);
      $display("abort during WAIT: wr0=%0d wr1=%0d", wr_cnt[0], wr_cnt[1]);
    end
    run_store(2'd2, 32'h105, 32'h000000A5, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_store(2'($urandom_range(0, 3)), 32'($urandom_range(0, 1023)), $urandom,
                1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/store_box.md
Name: store_box

Overview:
- Store-side counterpart of the load path in the multicycle RISC datapath.
- Executes sw/sh/sb by read-modify-write of the addressed 32-bit memory word.
  - Merges the byte or halfword from the register operand into the correct lane, then writes the word back.
- Sits between the control unit (start/done handshake) and the single-port data memory.
- The control unit holds its FSM in the store state until done.

Parameters:
- MEM_LATENCY, 1, cycles from mem_rd assertion to valid mem_rdata (legal range 1..7).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- store_type  input  2  00=word, 01=halfword, 10=byte, 11=reserved (treated as word).
- addr  input  32  byte address, sampled with start.
- wdata  input  32  register operand, sampled with start.
- mem_rdata  input  32  memory read data.
- mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- mem_wdata  output  32  merged word.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- misaligned  output  1  one-cycle pulse instead of done when the store is rejected.

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE.
  - mem_rd, mem_wr, done, misaligned, busy all 0; mem_addr and mem_wdata 0.
  - Reset mid-operation aborts immediately; no write is issued after reset.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - On start, latch addr/wdata/store_type.
  - Word store -> WRITE.
  - Half/byte store -> READ.
  - start while busy is ignored (not queued).
- READ: mem_rd=1 for one cycle; load wait counter with MEM_LATENCY-1; go to WAIT.
- WAIT: decrement counter each cycle.
  - At 0, capture mem_rdata into a merge register; go to WRITE.
  - MEM_LATENCY=1: WAIT lasts exactly one cycle.
- WRITE: mem_wr=1 for one cycle with mem_wdata = merged word; go to DONE.
- DONE: done=1 for one cycle; return to IDLE.
- mem_addr is held stable from READ through WRITE.
- Latency, start to done pulse:
  - Word: 2 cycles.
  - Half/byte: 3+MEM_LATENCY cycles.
- Lane rules (little-endian, lane select from addr[1:0]):
  - Byte: lane k=addr[1:0]; bits [8k+7:8k] = wdata[7:0]; other bytes keep the read value.
  - Halfword: addr[1]=0 -> bits [15:0] = wdata[15:0]; addr[1]=1 -> bits [31:16] = wdata[15:0].
  - Word: mem_wdata = wdata. addr[1:0] is ignored unless the alignment check is enabled.
- Back-to-back: start is accepted on the IDLE cycle following DONE, so minimum spacing is latency+1.

Optional Feature:
- Macro: STORE_BOX_ALIGN_CHECK_EN.
- Defined: in IDLE, a halfword with addr[0]=1 or a word with addr[1:0]!=0 goes directly to DONE.
  - No mem_rd or mem_wr is issued.
  - misaligned=1 instead of done in that cycle.
- Undefined: misaligned is tied 0; low address bits are ignored as described in Behaviour.

Decomposition:
- store_box_pkg holds:
  - store_type_t enum (ST_WORD, ST_HALF, ST_BYTE).
  - state_t enum.
  - Constant for the word-align mask.
- Sub-module store_lane_merge: purely combinational. Inputs are old word, wdata, store_type and addr[1:0]; output is the merged word. It is instantiated once and is unit-testable on its own.

Test Plan:
- Byte store: mem word 0xAABBCCDD, start sb, addr=0x102, wdata=0x12345677 -> one mem_rd, then mem_wr with mem_addr=0x100, mem_wdata=0xAA77CCDD; done at cycle 4 (MEM_LATENCY=1).
- Halfword store: mem word 0x11223344, sh, addr=0x202, wdata=0xFFFFBEEF -> mem_wdata=0xBEEF3344; same at addr=0x200 -> 0x1122BEEF.
- Word store: sw, addr=0x40, wdata=0xDEADBEEF -> no mem_rd; mem_wr in cycle 1 with 0xDEADBEEF; done in cycle 2.
- MEM_LATENCY=3, byte store -> exactly 3 WAIT cycles; merge uses mem_rdata from the 3rd cycle; done at cycle 6.
- reset=0 asserted during WAIT -> mem_wr never asserts, all outputs 0 next cycle; a new start after release completes normally.
- With STORE_BOX_ALIGN_CHECK_EN, sh at addr=0x203 -> misaligned pulse one cycle after start, no memory strobes, done stays 0.
